// File: rtl/frame_source_arbiter.sv
// Per-frame arbiter that shares one 17-bit pixel queue between the camera path and the pattern generator.
// Grants switch only on start/end markers, and a granted frame that goes silent is closed with a forced end marker.
module frame_source_arbiter #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel_pattern,
  input  logic [16:0]          cam_queue_data,
  input  logic                 cam_queue_wr_en,
  output logic                 cam_queue_full,
  input  logic [16:0]          pat_queue_data,
  input  logic                 pat_queue_wr_en,
  output logic                 pat_queue_full,
  output logic [16:0]          queue_data,
  output logic                 queue_wr_en,
  input  logic                 queue_full,
  output logic [1:0]           active_src,
  output logic [CNT_WIDTH-1:0] discard_count,
  output logic                 timeout_event,
  output logic                 overflow
);

  localparam int          TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] SOF = 17'h10000;
  localparam logic [16:0] EOF = 17'h1FFFF;

  typedef enum logic [1:0] {IDLE, IN_FRAME, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        tmr, tmr_d;
  logic                 cam_elig, pat_elig, cam_acc, pat_acc, acc, tmr_expire, drop;
  logic [16:0]          acc_data, data_d;
  logic                 wr_d, to_d;
  logic [1:0]           src_d, disc_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic [1:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  // A source is eligible if it is requested while idle or granted mid-frame; nobody is during FLUSH.
  always_comb begin
    cam_elig = ((state == IDLE) && !sel_pattern) || ((state == IN_FRAME) && (active_src == 2'd1));
    pat_elig = ((state == IDLE) &&  sel_pattern) || ((state == IN_FRAME) && (active_src == 2'd2));
  end

  assign cam_queue_full = cam_elig ? queue_full : 1'b1;
  assign pat_queue_full = pat_elig ? queue_full : 1'b1;
  assign cam_acc        = cam_queue_wr_en & ~cam_queue_full;
  assign pat_acc        = pat_queue_wr_en & ~pat_queue_full;
  assign acc            = cam_acc | pat_acc;
  assign acc_data       = cam_acc ? cam_queue_data : pat_queue_data;
  assign tmr_expire     = (state == IN_FRAME) && !acc && (tmr == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (acc && acc_data == SOF) state_nxt = IN_FRAME;
      IN_FRAME: if (acc && acc_data == EOF) state_nxt = IDLE;
                else if (tmr_expire)        state_nxt = FLUSH;
      FLUSH:    if (!queue_full)            state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_d   = 1'b0;
    data_d = queue_data;
    src_d  = active_src;
    to_d   = 1'b0;
    drop   = 1'b0;
    tmr_d  = '0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (acc_data == SOF) begin
            wr_d   = 1'b1;
            data_d = acc_data;
            src_d  = pat_acc ? 2'd2 : 2'd1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      IN_FRAME: begin
        tmr_d = tmr + TW'(1);
        if (acc) begin
          wr_d   = 1'b1;
          data_d = acc_data;
          tmr_d  = '0;
          if (acc_data == EOF) src_d = 2'd0;
        end else if (tmr_expire) begin
          tmr_d = '0;
        end
      end
      FLUSH: begin
        if (!queue_full) begin
          wr_d   = 1'b1;
          data_d = EOF;
          to_d   = 1'b1;
          src_d  = 2'd0;
        end
      end
      default: ;
    endcase
    disc_inc = {1'b0, cam_queue_wr_en & ~cam_elig} + {1'b0, pat_queue_wr_en & ~pat_elig}
             + {1'b0, drop};
  end

  // Output register stage: everything visible on the queue side is one cycle behind acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      queue_data    <= '0;
      queue_wr_en   <= 1'b0;
      active_src    <= 2'd0;
      discard_count <= '0;
      timeout_event <= 1'b0;
      overflow      <= 1'b0;
      tmr           <= '0;
    end else begin
      queue_data    <= data_d;
      queue_wr_en   <= wr_d;
      active_src    <= src_d;
      discard_count <= sat_add(discard_count, disc_inc);
      timeout_event <= to_d;
      overflow      <= overflow | (queue_wr_en & queue_full);
      tmr           <= tmr_d;
    end
  end

endmodule

// File: tb/tb_frame_source_arbiter.sv
// Directed bench for frame_source_arbiter: grant/forward, source switching, discards, timeout flush,
// backpressure during flush, overflow, reset mid-frame and counter saturation.
module tb_frame_source_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel_pattern;
  logic [16:0] cam_queue_data, pat_queue_data, queue_data;
  logic        cam_queue_wr_en, pat_queue_wr_en, cam_queue_full, pat_queue_full;
  logic        queue_wr_en, queue_full, timeout_event, overflow;
  logic [1:0]  active_src;
  logic [3:0]  discard_count;

  int n_assert = 0;
  int n_fail   = 0;

  frame_source_arbiter #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .sel_pattern(sel_pattern),
    .cam_queue_data(cam_queue_data), .cam_queue_wr_en(cam_queue_wr_en), .cam_queue_full(cam_queue_full),
    .pat_queue_data(pat_queue_data), .pat_queue_wr_en(pat_queue_wr_en), .pat_queue_full(pat_queue_full),
    .queue_data(queue_data), .queue_wr_en(queue_wr_en), .queue_full(queue_full),
    .active_src(active_src), .discard_count(discard_count), .timeout_event(timeout_event),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic cam(input logic en, input logic [16:0] d);
    cam_queue_wr_en = en;
    cam_queue_data  = d;
  endtask

  initial begin
    reset = 1'b1; sel_pattern = 1'b0; queue_full = 1'b0;
    cam_queue_data = '0; cam_queue_wr_en = 1'b0; pat_queue_data = '0; pat_queue_wr_en = 1'b0;
    step(); step();
    chk("rst_wr", queue_wr_en, 0);
    chk("rst_data", queue_data, 0);
    chk("rst_src", active_src, 0);
    chk("rst_disc", discard_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_to", timeout_event, 0);
    chk("rst_camfull", cam_queue_full, 0);
    chk("rst_patfull", pat_queue_full, 1);
    reset = 1'b0;

    // 1: camera frame forwarded with one-cycle latency
    cam(1, 17'h10000); step();
    chk("t1_sof_wr", queue_wr_en, 1); chk("t1_sof_d", queue_data, 17'h10000); chk("t1_src", active_src, 1);
    cam(1, 17'h00123); step(); chk("t1_p0", queue_data, 17'h00123);
    cam(1, 17'h0ABCD); step(); chk("t1_p1", queue_data, 17'h0ABCD);
    cam(1, 17'h0F800); step(); chk("t1_p2", queue_data, 17'h0F800); chk("t1_p2_wr", queue_wr_en, 1);
    cam(1, 17'h1FFFF); step();
    chk("t1_eof_d", queue_data, 17'h1FFFF); chk("t1_eof_wr", queue_wr_en, 1); chk("t1_src0", active_src, 0);
    cam(0, 17'h0); step(); chk("t1_idle_wr", queue_wr_en, 0);

    // 2: pattern requested mid camera frame
    cam(1, 17'h10000); step(); chk("t2_src1", active_src, 1);
    sel_pattern = 1'b1; pat_queue_wr_en = 1'b1; pat_queue_data = 17'h00555;
    cam(1, 17'h00111); #1;
    chk("t2_patfull", pat_queue_full, 1); chk("t2_camfull", cam_queue_full, 0);
    step(); chk("t2_pix", queue_data, 17'h00111); chk("t2_disc1", discard_count, 1);
    cam(1, 17'h1FFFF); step();
    chk("t2_eof", queue_data, 17'h1FFFF); chk("t2_disc2", discard_count, 2); chk("t2_src0", active_src, 0);
    cam(0, 17'h0); step(); chk("t2_drop_wr", queue_wr_en, 0); chk("t2_disc3", discard_count, 3);
    pat_queue_data = 17'h10000; step();
    chk("t2_psof", queue_data, 17'h10000); chk("t2_src2", active_src, 2); chk("t2_disc3b", discard_count, 3);
    pat_queue_data = 17'h1FFFF; step(); chk("t2_peof_src", active_src, 0);
    pat_queue_wr_en = 1'b0; sel_pattern = 1'b0;

    // 3: join mid-frame word dropped
    do_reset();
    cam(1, 17'h0F800); step(); chk("t3_wr", queue_wr_en, 0); chk("t3_disc", discard_count, 1);
    cam(1, 17'h10000); step(); chk("t3_sof", queue_data, 17'h10000); chk("t3_src", active_src, 1);

    // 4: silence forces a flush after eight idle cycles
    cam(1, 17'h00042); step(); chk("t4_pix", queue_data, 17'h00042);
    cam(0, 17'h0);
    for (int i = 0; i < 8; i++) begin step(); chk("t4_quiet_wr", queue_wr_en, 0); end
    step();
    chk("t4_flush_wr", queue_wr_en, 1); chk("t4_flush_d", queue_data, 17'h1FFFF);
    chk("t4_to", timeout_event, 1); chk("t4_src", active_src, 0);
    step(); chk("t4_to_once", timeout_event, 0); chk("t4_wr0", queue_wr_en, 0);

    // 4b: a write in the eighth idle cycle keeps the frame open
    cam(1, 17'h10000); step(); cam(0, 17'h0);
    for (int i = 0; i < 7; i++) step();
    cam(1, 17'h00077); step();
    chk("t4b_wr", queue_wr_en, 1); chk("t4b_d", queue_data, 17'h00077); chk("t4b_to", timeout_event, 0);
    cam(0, 17'h0); step();

    // 5: flush held off by a full queue
    queue_full = 1'b1;
    for (int i = 0; i < 7; i++) step();
    for (int i = 0; i < 5; i++) begin
      step(); chk("t5_hold_wr", queue_wr_en, 0); chk("t5_hold_to", timeout_event, 0);
    end
    chk("t5_camfull", cam_queue_full, 1);
    queue_full = 1'b0; step();
    chk("t5_eof", queue_data, 17'h1FFFF); chk("t5_wr", queue_wr_en, 1); chk("t5_to", timeout_event, 1);
    step(); chk("t5_single", queue_wr_en, 0); chk("t5_noovf", overflow, 0);

    cam(1, 17'h10000); step(); cam(0, 17'h0);
    queue_full = 1'b1; step(); chk("t5_ovf", overflow, 1);
    queue_full = 1'b0; step(); chk("t5_ovf_sticky", overflow, 1);

    // 6: reset mid-frame
    cam(1, 17'h00321); step(); chk("t6_pre", active_src, 1);
    cam(0, 17'h0); reset = 1'b1; step();
    chk("t6_wr", queue_wr_en, 0); chk("t6_src", active_src, 0); chk("t6_ovf", overflow, 0);
    chk("t6_data", queue_data, 0); chk("t6_disc", discard_count, 0);
    reset = 1'b0;
    cam(1, 17'h00099); step(); chk("t6_drop", queue_wr_en, 0); chk("t6_src_still0", active_src, 0);
    cam(1, 17'h10000); step(); chk("t6_regrant", active_src, 1);

    // discard counter: +2 per cycle, saturating at all-ones
    do_reset();
    pat_queue_wr_en = 1'b1; pat_queue_data = 17'h00000; cam(1, 17'h00001);
    for (int i = 0; i < 7; i++) step();
    chk("sat_14", discard_count, 14);
    step(); chk("sat_15", discard_count, 15);
    step(); chk("sat_hold", discard_count, 15);
    pat_queue_wr_en = 1'b0; cam(0, 17'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
